// File: rtl/ibex_counter_reader_if.sv
// Request/grant/rvalid register bus between a CSR/peripheral master and the
// counter reader. The master drives the request side; the slave answers.
interface ibex_counter_reader_if;
    logic        req;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ibex_counter_reader.sv
// Tear-free 32-bit reader for a live 64-bit counter, with an optional compare
// register and level interrupt enabled by IBEX_COUNTER_READER_CMP_EN.
//
// state | meaning
// IDLE  | ready; gnt follows req and the response is captured on grant
// RESP  | rvalid high for exactly one cycle; no grant
module ibex_counter_reader #(
    parameter int unsigned CounterWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [63:0]          counter_val_i,
    ibex_counter_reader_if.slave bus,
    output logic                 irq_o
);

    localparam logic [1:0] AddrCntLo = 2'd0;
    localparam logic [1:0] AddrCntHi = 2'd1;
    localparam logic [1:0] AddrCmpLo = 2'd2;

    // Bits at or above CounterWidth are not part of the counter and read as 0.
    localparam logic [63:0] CntMask = (CounterWidth >= 64) ? {64{1'b1}}
                                      : ((64'd1 << CounterWidth) - 64'd1);

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    state_e      state_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] shadow_q;
    logic        shadow_valid_q;

    logic [63:0] cnt;
    logic [31:0] rdata_d;
    logic        err_d;
    logic [31:0] shadow_d;
    logic        shadow_valid_d;

`ifdef IBEX_COUNTER_READER_CMP_EN
    logic [63:0] cmp_q;
`endif

    assign cnt        = counter_val_i & CntMask;
    assign bus.gnt    = bus.req && (state_q == IDLE);
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;

    always_comb begin
        rdata_d        = '0;
        err_d          = 1'b0;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        unique case (bus.addr)
            AddrCntLo: begin
                if (bus.we) begin
                    err_d = 1'b1;
                end else begin
                    rdata_d        = cnt[31:0];
                    shadow_d       = cnt[63:32];
                    shadow_valid_d = 1'b1;
                end
            end
            AddrCntHi: begin
                if (bus.we) begin
                    err_d = 1'b1;
                end else if (shadow_valid_q) begin
                    rdata_d        = shadow_q;
                    shadow_valid_d = 1'b0;
                end else begin
                    rdata_d = cnt[63:32];
                end
            end
            default: begin
`ifdef IBEX_COUNTER_READER_CMP_EN
                // Compare writes answer with zero data; the register updates below.
                if (!bus.we) begin
                    rdata_d = (bus.addr == AddrCmpLo) ? cmp_q[31:0] : cmp_q[63:32];
                end
`else
                err_d = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            rvalid_q       <= 1'b0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.gnt) begin
                        state_q        <= RESP;
                        rvalid_q       <= 1'b1;
                        rdata_q        <= rdata_d;
                        err_q          <= err_d;
                        shadow_q       <= shadow_d;
                        shadow_valid_q <= shadow_valid_d;
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                    err_q    <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                    err_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef IBEX_COUNTER_READER_CMP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmp_q <= {64{1'b1}};
        end else if (bus.gnt && bus.we && bus.addr[1]) begin
            if (bus.addr[0]) begin
                cmp_q[63:32] <= bus.wdata;
            end else begin
                cmp_q[31:0] <= bus.wdata;
            end
        end
    end

    // Compare sees the previous cmp_q, so a write shows on irq_o two edges later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= (cnt >= cmp_q);
        end
    end
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_counter_reader.sv
// Randomised and directed bench for ibex_counter_reader: one 64-bit and one
// 40-bit instance checked against a register-level model of the reader.
module tb_ibex_counter_reader;

`ifdef IBEX_COUNTER_READER_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [63:0] counter_val;
    logic        irq_a, irq_b;

    logic        req_v[2], we_v[2];
    logic [1:0]  addr_v[2];
    logic [31:0] wdata_v[2];
    logic        gnt_v[2], rvalid_v[2], err_v[2];
    logic [31:0] rdata_v[2];

    int checks = 0;
    int errors = 0;

    // Reference model state, per instance
    logic [31:0] m_shadow[2];
    bit          m_sv[2];
    logic [63:0] m_cmp[2];

    ibex_counter_reader_if bus_a ();
    ibex_counter_reader_if bus_b ();

    assign bus_a.req = req_v[0];  assign bus_a.we = we_v[0];
    assign bus_a.addr = addr_v[0]; assign bus_a.wdata = wdata_v[0];
    assign bus_b.req = req_v[1];  assign bus_b.we = we_v[1];
    assign bus_b.addr = addr_v[1]; assign bus_b.wdata = wdata_v[1];
    assign gnt_v[0] = bus_a.gnt;  assign rvalid_v[0] = bus_a.rvalid;
    assign rdata_v[0] = bus_a.rdata; assign err_v[0] = bus_a.err;
    assign gnt_v[1] = bus_b.gnt;  assign rvalid_v[1] = bus_b.rvalid;
    assign rdata_v[1] = bus_b.rdata; assign err_v[1] = bus_b.err;

    ibex_counter_reader #(.CounterWidth(64)) dut_a (
        .clk_i(clk), .rst_i(rst), .counter_val_i(counter_val), .bus(bus_a), .irq_o(irq_a)
    );
    ibex_counter_reader #(.CounterWidth(40)) dut_b (
        .clk_i(clk), .rst_i(rst), .counter_val_i(counter_val), .bus(bus_b), .irq_o(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] visible(input int d, input logic [63:0] v);
        return (d == 0) ? v : (v % (64'd1 << 40));
    endfunction

    function automatic logic exp_irq(input int d);
        return CMP_EN && (visible(d, counter_val) >= m_cmp[d]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_shadow[d] = '0; m_sv[d] = 1'b0; m_cmp[d] = {64{1'b1}};
        end
    endtask

    task automatic model_xfer(input int d, input bit we, input logic [1:0] a,
                              input logic [31:0] wd, input logic [63:0] v,
                              output logic [31:0] r, output logic e);
        logic [63:0] c;
        c = visible(d, v);
        r = '0; e = 1'b0;
        if (a < 2) begin
            if (we) e = 1'b1;
            else if (a == 0) begin r = c[31:0]; m_shadow[d] = c[63:32]; m_sv[d] = 1'b1; end
            else if (m_sv[d]) begin r = m_shadow[d]; m_sv[d] = 1'b0; end
            else r = c[63:32];
        end else if (!CMP_EN) begin
            e = 1'b1;
        end else if (we) begin
            if (a == 2) m_cmp[d][31:0] = wd; else m_cmp[d][63:32] = wd;
        end else begin
            r = (a == 2) ? m_cmp[d][31:0] : m_cmp[d][63:32];
        end
    endtask

    // Returns #1 after the grant edge, i.e. in the response cycle.
    task automatic bus_xfer(input int d, input bit we, input logic [1:0] a, input logic [31:0] wd,
                            output logic [31:0] r, output logic e);
        int n = 0;
        req_v[d] = 1'b1; we_v[d] = we; addr_v[d] = a; wdata_v[d] = wd;
        @(negedge clk);
        while (gnt_v[d] !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        if (gnt_v[d] !== 1'b1) begin
            checks++; errors++;
            $display("FAIL grant_timeout dut=%0d addr=%0d got gnt=%b want 1", d, a, gnt_v[d]);
            req_v[d] = 1'b0; r = '0; e = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_v[d] = 1'b0;
        checks++;
        if (rvalid_v[d] !== 1'b1) begin
            errors++;
            $display("FAIL rvalid_latency dut=%0d got %b want 1", d, rvalid_v[d]);
        end
        r = rdata_v[d]; e = err_v[d];
    endtask

    task automatic xfer(input int d, input bit we, input logic [1:0] a, input logic [31:0] wd,
                        output logic [31:0] r, output logic e,
                        output logic [31:0] pr, output logic pe);
        model_xfer(d, we, a, wd, counter_val, pr, pe);
        bus_xfer(d, we, a, wd, r, e);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({rvalid_v[d], err_v[d], rdata_v[d], gnt_v[d]} !== 35'd0) begin
                errors++;
                $display("FAIL reset_bus dut=%0d got rvalid=%b err=%b rdata=%h gnt=%b want all 0",
                         d, rvalid_v[d], err_v[d], rdata_v[d], gnt_v[d]);
            end
        end
        checks++;
        if ({irq_a, irq_b} !== 2'b00) begin
            errors++; $display("FAIL reset_irq got %b%b want 00", irq_a, irq_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_tear_free();
        logic [31:0] r, pr; logic e, pe;
        @(posedge clk); #1;
        counter_val = 64'h0000_0001_FFFF_FFFF;
        xfer(0, 1'b0, 2'd0, '0, r, e, pr, pe);
        checks++;
        if (r !== 32'hFFFF_FFFF || e !== 1'b0) begin
            errors++; $display("FAIL tear_lo got %h/%b want ffffffff/0", r, e);
        end
        counter_val = 64'h0000_0002_0000_0000;
        xfer(0, 1'b0, 2'd1, '0, r, e, pr, pe);
        checks++;
        if (r !== 32'h0000_0001) begin
            errors++; $display("FAIL tear_hi_shadow got %h want 00000001", r);
        end
        xfer(0, 1'b0, 2'd1, '0, r, e, pr, pe);
        checks++;
        if (r !== 32'h0000_0002) begin
            errors++; $display("FAIL tear_hi_live got %h want 00000002", r);
        end
    endtask

    task automatic test_handshake();
        logic [3:0] g, v;
        int nresp = 0;
        @(posedge clk); #1;
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 2'd2; wdata_v[0] = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            g[k] = gnt_v[0]; v[k] = rvalid_v[0];
            if (rvalid_v[0] === 1'b1) nresp++;
            @(posedge clk); #1;
        end
        req_v[0] = 1'b0;
        @(negedge clk);
        if (rvalid_v[0] === 1'b1) nresp++;
        checks++;
        if (g !== 4'b0101) begin errors++; $display("FAIL hs_gnt got %b want 0101", g); end
        checks++;
        if (v !== 4'b1010) begin errors++; $display("FAIL hs_rvalid got %b want 1010", v); end
        checks++;
        if (nresp != 2) begin errors++; $display("FAIL hs_count got %0d want 2", nresp); end
    endtask

    task automatic test_compare();
        logic [31:0] r, pr; logic e, pe;
        logic [63:0] ramp[5] = '{64'd98, 64'd99, 64'd100, 64'd101, 64'd0};
        bit          want[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        @(posedge clk); #1;
        counter_val = 64'd0;
        xfer(0, 1'b1, 2'd3, 32'd0, r, e, pr, pe);
        checks++;
        if (e !== !CMP_EN || r !== 32'd0) begin
            errors++; $display("FAIL cmp_hi_write got %h/%b want 00000000/%b", r, e, !CMP_EN);
        end
        xfer(0, 1'b1, 2'd2, 32'd100, r, e, pr, pe);
        for (int k = 0; k < 5; k++) begin
            counter_val = ramp[k];
            @(posedge clk); #1;
            checks++;
            if (irq_a !== (want[k] && CMP_EN)) begin
                errors++;
                $display("FAIL cmp_irq cnt=%0d got %b want %b", ramp[k], irq_a, want[k] && CMP_EN);
            end
        end
    endtask

    task automatic test_error_path();
        logic [31:0] r, pr; logic e, pe;
        @(posedge clk); #1;
        counter_val = 64'h0000_0005_0000_0000;
        xfer(0, 1'b0, 2'd1, '0, r, e, pr, pe);
        xfer(0, 1'b1, 2'd0, 32'h1234, r, e, pr, pe);
        checks++;
        if (e !== 1'b1 || r !== 32'd0) begin
            errors++; $display("FAIL err_cnt_write got %h/%b want 00000000/1", r, e);
        end
        counter_val = 64'h0000_0007_0000_0003;
        xfer(0, 1'b0, 2'd1, '0, r, e, pr, pe);
        checks++;
        if (r !== 32'h0000_0007 || e !== 1'b0) begin
            errors++; $display("FAIL err_no_shadow got %h/%b want 00000007/0", r, e);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] r, pr; logic e, pe;
        @(posedge clk); #1;
        counter_val = 64'h0000_0009_0000_0010;
        xfer(0, 1'b0, 2'd0, '0, r, e, pr, pe);
        @(posedge clk); #1;
        counter_val = 64'h0000_000A_0000_0020;
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        model_reset();
        checks++;
        if ({rvalid_v[0], rdata_v[0], err_v[0], irq_a} !== 35'd0) begin
            errors++;
            $display("FAIL midop_reset got rvalid=%b rdata=%h err=%b irq=%b want all 0",
                     rvalid_v[0], rdata_v[0], err_v[0], irq_a);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid_v[0] !== 1'b0) begin
            errors++; $display("FAIL midop_late_rvalid got %b want 0", rvalid_v[0]);
        end
        @(posedge clk); #1;
        for (int a = 2; a < 4; a++) begin
            xfer(0, 1'b0, a[1:0], '0, r, e, pr, pe);
            checks++;
            if (r !== (CMP_EN ? 32'hFFFF_FFFF : 32'h0) || e !== !CMP_EN) begin
                errors++;
                $display("FAIL midop_cmp_readback addr=%0d got %h/%b want %h/%b",
                         a, r, e, CMP_EN ? 32'hFFFF_FFFF : 32'h0, !CMP_EN);
            end
        end
        xfer(0, 1'b0, 2'd1, '0, r, e, pr, pe);
        checks++;
        if (r !== 32'h0000_000A) begin
            errors++; $display("FAIL midop_cnt_hi got %h want 0000000a", r);
        end
    endtask

    task automatic test_width40();
        logic [31:0] r, pr; logic e, pe;
        @(posedge clk); #1;
        counter_val = {64{1'b1}};
        xfer(1, 1'b0, 2'd2, '0, r, e, pr, pe);
        checks++;
        if (e !== !CMP_EN) begin errors++; $display("FAIL w40_cmp_err got %b want %b", e, !CMP_EN); end
        xfer(1, 1'b0, 2'd0, '0, r, e, pr, pe);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL w40_lo got %h want ffffffff", r); end
        xfer(1, 1'b0, 2'd1, '0, r, e, pr, pe);
        checks++;
        if (r !== 32'h0000_00FF) begin errors++; $display("FAIL w40_hi got %h want 000000ff", r); end
        @(posedge clk); #1;
        checks++;
        if (irq_b !== 1'b0) begin errors++; $display("FAIL w40_irq got %b want 0", irq_b); end
    endtask

    task automatic test_random();
        logic [31:0] r, pr, wd; logic e, pe;
        int d; bit we; logic [1:0] a;
        for (int i = 0; i < 120; i++) begin
            d  = $urandom_range(0, 1);
            we = $urandom_range(0, 3) == 0;
            a  = 2'($urandom_range(0, 3));
            wd = (a == 2) ? 32'($urandom_range(0, 400))
               : ($urandom_range(0, 3) == 0 ? $urandom : 32'd0);
            case ($urandom_range(0, 2))
                0: counter_val = {$urandom, $urandom};
                1: counter_val = 64'($urandom_range(0, 400));
                default: ;
            endcase
            xfer(d, we, a, wd, r, e, pr, pe);
            checks++;
            if (r !== pr || e !== pe) begin
                errors++;
                $display("FAIL rand_resp i=%0d dut=%0d we=%b addr=%0d got %h/%b want %h/%b",
                         i, d, we, a, r, e, pr, pe);
            end
            @(posedge clk); #1;
            checks++;
            if (irq_a !== exp_irq(0) || irq_b !== exp_irq(1)) begin
                errors++;
                $display("FAIL rand_irq i=%0d got %b%b want %b%b", i, irq_a, irq_b, exp_irq(0), exp_irq(1));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        counter_val = '0;
        for (int d = 0; d < 2; d++) begin
            req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = '0; wdata_v[d] = '0;
        end
        model_reset();
        test_reset();
        test_tear_free();
        test_handshake();
        test_compare();
        test_error_path();
        test_reset_midop();
        test_width40();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
